// File: rtl/interrupt_controller.sv
// Device interrupt front end: synchronises and edge-detects irq lines into pending
// pulses for the CRF, and arbitrates masked pending bits into a req/ack request.

module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic evt
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev resets low, so a line already high at reset release yields one event
    assign evt = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

module interrupt_controller #(
    parameter int          NUM_IRQ     = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               stall,
    output logic [NUM_IRQ-1:0] irq_pulse,
    input  logic [31:0]        interrupt_state,
    output logic               int_req,
    input  logic               int_ack,
    output logic [3:0]         int_index,
    output logic [31:0]        int_vector,
    output logic [31:0]        int_efg,
    input  logic               rfi_in_wb,
    output logic               in_service
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    logic [NUM_IRQ-1:0] evt;
    logic [NUM_IRQ-1:0] pending_set;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] onehot;
    logic [3:0]         win_idx;
    logic [3:0]         cap_idx;
    state_t             state;
    logic               unused_state_hi;

    genvar g;
    generate
        for (g = 0; g < NUM_IRQ; g++) begin : g_line
            irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_line (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (irq_in[g]),
                .evt   (evt[g])
            );
        end
    endgenerate

    // Held while stalled so the CRF accumulator cannot miss it; a new event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_set <= '0;
        else        pending_set <= (pending_set & {NUM_IRQ{stall}}) | evt;
    end

    assign irq_pulse       = pending_set;
    assign cand            = interrupt_state[NUM_IRQ-1:0];
    assign unused_state_hi = ^interrupt_state[31:NUM_IRQ];

    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (cand[i]) win_idx = 4'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_idx    <= '0;
            int_req    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|cand) begin
                    cap_idx <= win_idx;
                    int_req <= 1'b1;
                    state   <= REQ;
                end
                REQ: if (int_ack) begin
                    int_req    <= 1'b0;
                    in_service <= 1'b1;
                    state      <= SERVICE;
                end else if (!cand[cap_idx]) begin
                    int_req <= 1'b0;
                    state   <= IDLE;
                end
                SERVICE: if (rfi_in_wb) begin
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign onehot     = NUM_IRQ'(1) << cap_idx;
    assign int_index  = int_req ? cap_idx : 4'd0;
    assign int_vector = int_req ? VEC_BASE + {26'b0, cap_idx, 2'b00} : 32'd0;
    assign int_efg    = int_req ? {{(32-NUM_IRQ){1'b0}}, onehot} : 32'd0;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed test-plan scenarios plus randomized traffic against a cycle model of
// the controller built from its rules (sample history, lowest-set-bit priority).

module tb_interrupt_controller;
    localparam int          S  = 2;
    localparam logic [31:0] VB = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] irq_in = '0;
    logic        stall = 1'b0;
    logic [15:0] irq_pulse;
    logic [31:0] interrupt_state = '0;
    logic        int_req;
    logic        int_ack = 1'b0;
    logic [3:0]  int_index;
    logic [31:0] int_vector;
    logic [31:0] int_efg;
    logic        rfi_in_wb = 1'b0;
    logic        in_service;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [15:0] hist[$];
    logic [15:0] m_pend;
    int          m_phase;   // 0 idle, 1 requesting, 2 in service
    int          m_cap;

    interrupt_controller #(.NUM_IRQ(16), .SYNC_STAGES(S), .VEC_BASE(VB)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .stall(stall), .irq_pulse(irq_pulse),
        .interrupt_state(interrupt_state), .int_req(int_req), .int_ack(int_ack),
        .int_index(int_index), .int_vector(int_vector), .int_efg(int_efg),
        .rfi_in_wb(rfi_in_wb), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist = {};
        repeat (S + 2) hist.push_back(16'h0);
        m_pend  = '0;
        m_phase = 0;
        m_cap   = 0;
    endtask

    task automatic model_edge();
        logic [15:0] ev, cand, low;
        hist.push_front(irq_in);
        // rising edge of the input as it was seen S samples ago
        ev = hist[S] & ~hist[S+1];
        void'(hist.pop_back());
        m_pend = (stall ? m_pend : 16'h0) | ev;
        cand = interrupt_state[15:0];
        case (m_phase)
            0: if (cand != 0) begin
                low = cand & (~cand + 16'd1);
                m_cap = $clog2(low);
                m_phase = 1;
            end
            1: if (int_ack) m_phase = 2;
               else if (!cand[m_cap]) m_phase = 0;
            default: if (rfi_in_wb) m_phase = 0;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({irq_pulse, int_req, int_index, int_vector, int_efg, in_service} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: pulse=%h req=%b idx=%0d vec=%h efg=%h svc=%b, required all 0",
                     irq_pulse, int_req, int_index, int_vector, int_efg, in_service);
        end
        do_reset();
        step();
        n_cmp++;
        if ({irq_pulse, int_req, in_service} !== '0) begin
            n_err++;
            $display("FAIL reset_idle: pulse=%h req=%b svc=%b, required 0", irq_pulse, int_req, in_service);
        end
    endtask

    task automatic test_edge();
        logic [15:0] exp;
        irq_in = 16'h0020;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp = (c == 3) ? 16'h0020 : 16'h0000;
            n_cmp++;
            if (irq_pulse !== exp) begin
                n_err++;
                $display("FAIL edge_pulse c%0d: got %h, required %h", c, irq_pulse, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp;
        irq_in = '0;
        repeat (4) step();
        stall  = 1'b1;
        irq_in = 16'h0001;
        for (int c = 1; c <= 9; c++) begin
            if (c == 7) stall = 1'b0;
            step();
            exp = (c >= 3 && c <= 6) ? 16'h0001 : 16'h0000;
            n_cmp++;
            if (irq_pulse !== exp) begin
                n_err++;
                $display("FAIL stall_hold c%0d: got %h, required %h", c, irq_pulse, exp);
            end
        end
        irq_in = '0;
    endtask

    task automatic test_priority();
        interrupt_state = 32'h8000_0014;
        step();
        n_cmp++;
        if ({int_req, int_index, int_vector, int_efg} !== {1'b1, 4'd2, 32'h208, 32'h4}) begin
            n_err++;
            $display("FAIL prio_req: req=%b idx=%0d vec=%h efg=%h, required 1/2/208/4",
                     int_req, int_index, int_vector, int_efg);
        end
        interrupt_state = 32'h8000_0015;
        step();
        n_cmp++;
        if ({int_req, int_index, int_vector, int_efg} !== {1'b1, 4'd2, 32'h208, 32'h4}) begin
            n_err++;
            $display("FAIL prio_stable: req=%b idx=%0d vec=%h efg=%h, required 1/2/208/4",
                     int_req, int_index, int_vector, int_efg);
        end
    endtask

    task automatic test_handshake();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        n_cmp++;
        if ({int_req, in_service, int_vector, int_efg} !== {2'b01, 64'h0}) begin
            n_err++;
            $display("FAIL hs_ack: req=%b svc=%b vec=%h efg=%h, required 0/1/0/0",
                     int_req, in_service, int_vector, int_efg);
        end
        interrupt_state = 32'h8000_0010;
        step();
        n_cmp++;
        if ({int_req, in_service} !== 2'b01) begin
            n_err++;
            $display("FAIL hs_no_rfi: req=%b svc=%b, required 0/1", int_req, in_service);
        end
        rfi_in_wb = 1'b1;
        step();
        rfi_in_wb = 1'b0;
        n_cmp++;
        if ({int_req, in_service} !== 2'b00) begin
            n_err++;
            $display("FAIL hs_rfi: req=%b svc=%b, required 0/0", int_req, in_service);
        end
        step();
        n_cmp++;
        if ({int_req, int_index, int_vector} !== {1'b1, 4'd4, 32'h210}) begin
            n_err++;
            $display("FAIL hs_rearb: req=%b idx=%0d vec=%h, required 1/4/210", int_req, int_index, int_vector);
        end
    endtask

    task automatic test_withdraw();
        interrupt_state = 32'h0;
        step();
        interrupt_state = 32'h8000_0008;
        step();
        n_cmp++;
        if ({int_req, int_index} !== {1'b1, 4'd3}) begin
            n_err++;
            $display("FAIL wd_req: req=%b idx=%0d, required 1/3", int_req, int_index);
        end
        interrupt_state = 32'h0;
        step();
        n_cmp++;
        if ({int_req, in_service, int_index} !== {2'b00, 4'd0}) begin
            n_err++;
            $display("FAIL wd_drop: req=%b svc=%b idx=%0d, required 0/0/0", int_req, in_service, int_index);
        end
        step();
        n_cmp++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL wd_idle: req=%b, required 0", int_req);
        end
        // ack in the same cycle the source disappears still counts
        interrupt_state = 32'h8000_0008;
        step();
        interrupt_state = 32'h0;
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        n_cmp++;
        if ({int_req, in_service} !== 2'b01) begin
            n_err++;
            $display("FAIL wd_ack_wins: req=%b svc=%b, required 0/1", int_req, in_service);
        end
    endtask

    task automatic test_reset_mid_service();
        stall  = 1'b1;
        irq_in = 16'h0080;
        repeat (3) step();
        n_cmp++;
        if ({irq_pulse, in_service} !== {16'h0080, 1'b1}) begin
            n_err++;
            $display("FAIL rms_setup: pulse=%h svc=%b, required 0080/1", irq_pulse, in_service);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({irq_pulse, int_req, int_index, int_vector, int_efg, in_service} !== '0) begin
            n_err++;
            $display("FAIL rms_async: pulse=%h req=%b svc=%b, required all 0", irq_pulse, int_req, in_service);
        end
        irq_in = '0;
        stall  = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if ({irq_pulse, int_req, in_service} !== '0) begin
                n_err++;
                $display("FAIL rms_after c%0d: pulse=%h req=%b svc=%b, required 0", c, irq_pulse, int_req, in_service);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e_vec, e_efg;
        logic [3:0]  e_idx;
        irq_in = 16'($urandom);
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 16; b++)
                if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
            stall           = ($urandom_range(2) == 0);
            interrupt_state = ($urandom_range(1) == 0) ? 32'h0 : {1'b1, 15'h0, 16'($urandom & $urandom)};
            int_ack         = ($urandom_range(2) == 0);
            rfi_in_wb       = ($urandom_range(3) == 0);
            step();
            e_idx = (m_phase == 1) ? 4'(m_cap) : 4'd0;
            e_vec = (m_phase == 1) ? VB + 32'(4 * m_cap) : 32'd0;
            e_efg = (m_phase == 1) ? (32'd1 << m_cap) : 32'd0;
            n_cmp++;
            if (irq_pulse !== m_pend) begin
                n_err++;
                $display("FAIL rnd_pulse c%0d: got %h, required %h", c, irq_pulse, m_pend);
            end
            n_cmp++;
            if ({int_req, in_service} !== {m_phase == 1, m_phase == 2}) begin
                n_err++;
                $display("FAIL rnd_fsm c%0d: req=%b svc=%b, required phase %0d", c, int_req, in_service, m_phase);
            end
            n_cmp++;
            if ({int_index, int_vector, int_efg} !== {e_idx, e_vec, e_efg}) begin
                n_err++;
                $display("FAIL rnd_vec c%0d: idx=%0d vec=%h efg=%h, required %0d/%h/%h",
                         c, int_index, int_vector, int_efg, e_idx, e_vec, e_efg);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_edge();
        test_stall();
        test_priority();
        test_handshake();
        test_withdraw();
        test_reset_mid_service();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Device-side front end of the interrupt path. It synchronizes asynchronous device interrupt lines and edge-detects them.
- It delivers one-cycle pending pulses into the control register file's interrupt-pending accumulator (the `interrupts` input), holding them across stalls.
- In the reverse direction it consumes the masked `interrupt_state` and arbitrates among pending sources. It raises a req/ack interrupt request to the pipeline carrying the winning vector and exception flags, then blocks further requests until the handler's return-from-interrupt reaches writeback.

Parameters:
- NUM_IRQ, 16, number of device interrupt lines (fixed width of the `interrupts` field; not to be exceeded).
- SYNC_STAGES, 2, flops in each input synchronizer chain (minimum 2).
- VEC_BASE, 32'h0000_0200, base address of the interrupt vector table; entries are 4 bytes apart.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- irq_in  input  16  asynchronous level interrupt lines from devices; a rising edge is an event.
- stall  input  1  pipeline stall; same signal the control register file uses to gate its accumulator update.
- irq_pulse  output  16  pending-event bits into the control register file's `interrupts` input.
- interrupt_state  input  32  masked pending bits from the control register file; zero when the global enable (bit 31) is clear.
- int_req  output  1  interrupt request to the pipeline.
- int_ack  input  1  pipeline accepted the request; it is injected toward writeback.
- int_index  output  4  winning source index while int_req is high.
- int_vector  output  32  VEC_BASE + 4*int_index.
- int_efg  output  32  exception flags for writeback: {16'b0, one-hot of int_index}.
- rfi_in_wb  input  1  return-from-interrupt retiring in writeback.
- in_service  output  1  high from ack until rfi_in_wb.

Behaviour:
- Reset (async, rst_n low):
  - Synchronizer flops, edge-history flops and pending_set are cleared.
  - FSM goes to IDLE.
  - All outputs are 0. int_vector reads 0 in reset; outside reset, int_vector and int_efg are 0 whenever int_req is 0.
  - Reset mid-request or mid-service drops everything; undelivered events are lost.
- Edge detection:
  - Each irq_in bit passes through SYNC_STAGES flops. An event is sync_out & ~prev, where prev is the last sync_out.
  - Because prev resets to 0, a line already high at reset release produces exactly one event.
- Delivery, latency and stalls:
  - On each clk edge, pending_set <= (pending_set & {16{stall}}) | event. Set wins over clear in the same cycle.
  - irq_pulse = pending_set, so a bit is asserted for one cycle when stall is low and is held while stall is high.
  - Latency with SYNC_STAGES=2: irq_pulse rises after the 3rd posedge at which irq_in is high.
  - Repeated edges on one bit before delivery merge into one pulse.
- Arbitration: cand = interrupt_state[15:0]. The winner is the lowest set index (bit 0 has highest priority).
- FSM states:
  - IDLE: int_req=0. If cand != 0, capture the winner index and go to REQ.
  - REQ: int_req=1. int_index, int_vector and int_efg hold the captured index and stay stable regardless of new higher-priority bits.
    - If int_ack is high: go to SERVICE.
    - Else, if interrupt_state[captured] is 0 (masked or cleared by software): withdraw, int_req drops, go to IDLE.
    - An ack in the same cycle as the bit dropping counts as accepted.
  - SERVICE: int_req=0, in_service=1, no new requests. On rfi_in_wb go to IDLE. Arbitration restarts the following cycle.
- rfi_in_wb is ignored in IDLE and REQ. int_ack is ignored outside REQ.
- int_vector arithmetic: 32-bit, VEC_BASE + {26'b0, int_index, 2'b00}, no overflow check.

Test Plan:
- Edge, no stall: irq_in[5] 0->1 at cycle 0 and held -> irq_pulse = 16'h0020 for exactly one cycle at cycle 3. No further pulse while the line stays high.
- Stall hold: irq_in[0] rises with stall=1 for 6 cycles -> irq_pulse[0] held high through the stall, cleared one cycle after stall falls. Exactly one delivery.
- Priority and stability: interrupt_state = 32'h8000_0014 -> int_req=1, int_index=2, int_vector=32'h208, int_efg=32'h4. Then set bit 0 in interrupt_state before ack -> outputs unchanged.
- Handshake: in REQ assert int_ack for 1 cycle -> int_req=0 and in_service=1 the next cycle. rfi_in_wb pulse with interrupt_state=32'h8000_0010 -> IDLE, then REQ with int_index=4.
- Withdraw: in REQ with index 3, drop interrupt_state to 0 (global disable) and hold int_ack=0 -> int_req low the next cycle, FSM in IDLE.
- Reset mid-service: rst_n low during SERVICE with a pending_set bit -> all outputs 0 immediately (async). After release, no pulse unless a new edge arrives.
